// File: rtl/hwag_cap_if.sv
// Tooth-capture bus between the hwag core (master) and the capture front end (slave).
// The master drives the raw VR level and the filter/period limits; the slave returns the capture results.
interface hwag_cap_if #(
   parameter int FILT_W = 8,
   parameter int PER_W  = 24
);
   logic              cap_in;
   logic [FILT_W-1:0] filt_len;
   logic [PER_W-1:0]  min_cap;
   logic [PER_W-1:0]  max_cap;
   logic              cap_out;
   logic              edge_stb;
   logic [PER_W-1:0]  period;
   logic              period_vld;
   logic              gap_det;
   logic              short_err;
   logic              stall;

   modport master (
      output cap_in, filt_len, min_cap, max_cap,
      input  cap_out, edge_stb, period, period_vld, gap_det, short_err, stall
   );

   modport slave (
      input  cap_in, filt_len, min_cap, max_cap,
      output cap_out, edge_stb, period, period_vld, gap_det, short_err, stall
   );
endinterface

// File: rtl/hwag_tooth_cap.sv
// Crank-tooth capture: synchronise and glitch-filter the VR input, then measure tooth periods.
// Build with HWAG_CAP_GAP_EN defined to include the missing-tooth gap detector.
module hwag_tooth_cap #(
   parameter int FILT_W = 8,
   parameter int PER_W  = 24
) (
   input logic       clk,
   input logic       rst,
   hwag_cap_if.slave tooth_if
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic              s1_q, s2_q;
   logic [FILT_W-1:0] fcnt_q, fcnt_d;
   logic              cap_out_q, cap_out_d;
   logic              rise_s;
   logic [1:0]        state_q, state_d;
   logic [PER_W-1:0]  cnt_q, cnt_d;
   logic [PER_W:0]    cnt_inc_s;
   logic              edge_stb_q, edge_stb_d;
   logic [PER_W-1:0]  period_q, period_d;
   logic              period_vld_q, period_vld_d;
   logic              short_err_q, short_err_d;
   logic              stall_q, stall_d;
   logic              stall_ent_s;

   // A new level must be seen on filt_len+1 consecutive synchronised samples before it is accepted.
   always_comb begin
      fcnt_d    = '0;
      cap_out_d = cap_out_q;
      rise_s    = 1'b0;
      if (s2_q != cap_out_q) begin
         if (fcnt_q >= tooth_if.filt_len) begin
            cap_out_d = s2_q;
            rise_s    = s2_q;
         end else begin
            fcnt_d = fcnt_q + FILT_W'(1);
         end
      end else begin
         fcnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         fcnt_q    <= '0;
         cap_out_q <= 1'b0;
      end else begin
         s1_q      <= tooth_if.cap_in;
         s2_q      <= s1_q;
         fcnt_q    <= fcnt_d;
         cap_out_q <= cap_out_d;
      end
   end

   assign cnt_inc_s = {1'b0, cnt_q} + {{PER_W{1'b0}}, 1'b1};

   // cnt+1 is the period a rising edge in this cycle would report; an edge always beats the timeout.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      edge_stb_d   = 1'b0;
      period_d     = period_q;
      period_vld_d = 1'b0;
      short_err_d  = 1'b0;
      stall_d      = stall_q;
      stall_ent_s  = 1'b0;
      case (state_q)
         ST_IDLE, ST_STALL: begin
            cnt_d = '0;
            if (rise_s) begin
               edge_stb_d = 1'b1;
               stall_d    = 1'b0;
               state_d    = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (rise_s && (cnt_inc_s >= {1'b0, tooth_if.min_cap})) begin
               edge_stb_d   = 1'b1;
               period_vld_d = 1'b1;
               period_d     = cnt_inc_s[PER_W-1:0];
               cnt_d        = '0;
            end else if (!rise_s && (cnt_inc_s >= {1'b0, tooth_if.max_cap})) begin
               state_d     = ST_STALL;
               stall_d     = 1'b1;
               stall_ent_s = 1'b1;
               cnt_d       = '0;
            end else begin
               short_err_d = rise_s;
               cnt_d       = (cnt_q >= tooth_if.max_cap) ? cnt_q : cnt_inc_s[PER_W-1:0];
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            stall_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         edge_stb_q   <= 1'b0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         short_err_q  <= 1'b0;
         stall_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         edge_stb_q   <= edge_stb_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         short_err_q  <= short_err_d;
         stall_q      <= stall_d;
      end
   end

`ifdef HWAG_CAP_GAP_EN
   logic [PER_W-1:0] prev_q, prev_d;
   logic             prev_vld_q, prev_vld_d;
   logic             gap_det_q, gap_det_d;

   // A gap is a period at least twice the previous one; the first period after a (re)start only primes prev.
   always_comb begin
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      gap_det_d  = 1'b0;
      if (period_vld_d) begin
         gap_det_d  = prev_vld_q && ({1'b0, period_d} >= {prev_q, 1'b0});
         prev_d     = period_d;
         prev_vld_d = 1'b1;
      end else if (stall_ent_s) begin
         prev_vld_d = 1'b0;
      end else begin
         prev_vld_d = prev_vld_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         gap_det_q  <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         gap_det_q  <= gap_det_d;
      end
   end

   assign tooth_if.gap_det = gap_det_q;
`else
   assign tooth_if.gap_det = 1'b0;
`endif

   assign tooth_if.cap_out    = cap_out_q;
   assign tooth_if.edge_stb   = edge_stb_q;
   assign tooth_if.period     = period_q;
   assign tooth_if.period_vld = period_vld_q;
   assign tooth_if.short_err  = short_err_q;
   assign tooth_if.stall      = stall_q;

endmodule
